// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the unified memory of the multicycle MIPS datapath between the CPU
// control path and a debug/loader port. One requester is granted at a time.
// The memory port is driven for MEM_LAT cycles, then the winner gets its read
// data and a one-cycle ack.
//
// Handshake: a requester raises req with we/addr/wdata stable and holds them
// until it sees its one-cycle ack. It drops req on the edge that samples ack.
// A req still high in the following IDLE cycle is a new access. Requests are
// only looked at in IDLE. A req dropped mid-access does not cancel the access.
module mem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MEM_LAT  = 2,
    parameter int CPU_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic [DW-1:0] dbg_rdata,
    output logic          dbg_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    fsm_state
);

    localparam int CW = $clog2(MEM_LAT) + 1;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DBG = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_owner_q, last_owner_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          grant_dbg;

    // Winner selection: a lone requester wins; on a conflict the CPU wins under
    // fixed priority, otherwise whichever port was not served last.
    always_comb begin
        grant_dbg = dbg_req;
        if (cpu_req && dbg_req) begin
            if (CPU_PRIO != 0) begin
                grant_dbg = 1'b0;
            end else begin
                grant_dbg = (last_owner_q == OWN_CPU);
            end
        end
    end

    // State register; reset drops the FSM to IDLE so mem_en/mem_we/acks fall at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> BUSY on any request, BUSY -> RESP when the count expires.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (cpu_req || dbg_req) state_d = S_BUSY;
            S_BUSY:  if (cnt_q == '0) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: latch the winning request, count the access, capture read data.
    always_comb begin
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dbg_rdata_d  = dbg_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req || dbg_req) begin
                    owner_d = grant_dbg ? OWN_DBG : OWN_CPU;
                    we_d    = grant_dbg ? dbg_we : cpu_we;
                    addr_d  = grant_dbg ? dbg_addr : cpu_addr;
                    wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
                    cnt_d   = CW'(MEM_LAT - 1);
                end
            end
            S_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (!we_q) begin
                    // Only the owner's read register moves; writes leave both alone.
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = mem_rdata;
                    end else begin
                        cpu_rdata_d = mem_rdata;
                    end
                end
            end
            S_RESP: begin
                last_owner_d = owner_q;
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; last_owner resets to DBG so the CPU wins the first conflict.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            owner_q      <= OWN_CPU;
            last_owner_q <= OWN_DBG;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cpu_rdata_q  <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Output decode: memory strobes only in BUSY, the owner's ack only in RESP.
    always_comb begin
        mem_en  = (state_q == S_BUSY);
        mem_we  = (state_q == S_BUSY) && we_q;
        cpu_ack = (state_q == S_RESP) && (owner_q == OWN_CPU);
        dbg_ack = (state_q == S_RESP) && (owner_q == OWN_DBG);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign fsm_state = state_q;

endmodule
